instr_fetch_unit: RTL and testbench

Instruction fetch unit: the requester side of the word-addressed, combinational-read instruction memory. It owns the program counter, drives the byte address to the memory, and registers the returned word plus its PC into an IF/ID output stage with a valid/ready handshake toward decode. It also handles stall, branch/jump redirect with flush, and halt on out-of-range PC. It sits between the instruction memory and the decoder in the pipelined CPU.

---
 rtl/ifu_pkg.sv | 17 +
 rtl/instr_fetch_unit.sv | 128 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
//   ifu_state_e       - fetch FSM state encoding
//   WORD_BYTES        - bytes per instruction word (PC step)
//   DEFAULT_RESET_PC  - default PC loaded on reset
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } ifu_state_e;

  localparam int unsigned WORD_BYTES = 4;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : ifu_pkg

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, addresses the combinational-read instruction
// memory and registers the returned word into an IF/ID stage toward decode.
//
// Ports
//   clk_i, rst_i          clock, async active-low reset
//   start_i               leave IDLE and begin fetching
//   pc_addr_o / instr_i   byte address to memory / word returned
//   redirect_i/_pc_i      branch/jump taken, target byte address
//   valid_o / ready_i     output-stage handshake toward decode
//   instr_o, pc_o         fetched word and its PC
//   pc_plus4_o            pc_o + 4 (wraps)
//   halted_o              FSM in HALT
//   misalign_o            sticky: a redirect target had nonzero bits [1:0]
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start_i; redirects only load the PC
// RUN   | fetching one word per cycle when the output stage can take it
// HALT  | PC ran past the memory; output drains, redirect in range resumes
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 32,
  parameter int unsigned        MEM_WORDS = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] pc_addr_o,
  input  logic [31:0]       instr_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic              halted_o,
  output logic              misalign_o
);

  localparam logic [ADDR_W-1:0] PC_LIMIT = ADDR_W'(MEM_WORDS * WORD_BYTES);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(WORD_BYTES);

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic              valid_q;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] pc_out_q;
  logic              misalign_q;

  logic [ADDR_W-1:0] redirect_aligned;
  logic              pc_in_range;
  logic              target_in_range;
  logic              fire;
  logic              capture_en;

  assign redirect_aligned = {redirect_pc_i[ADDR_W-1:2], 2'b00};
  assign pc_in_range      = (pc_q < PC_LIMIT);
  assign target_in_range  = (redirect_aligned < PC_LIMIT);
  assign fire             = valid_q && ready_i;
  assign capture_en       = (!valid_q || ready_i) && (state_q == RUN)
                            && !redirect_i && pc_in_range;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect outranks everything in every state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!redirect_i && start_i) state_d = RUN;
      end
      RUN: begin
        if (!redirect_i && !pc_in_range) state_d = HALT;
      end
      HALT: begin
        if (redirect_i && target_in_range) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // PC and IF/ID output stage
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_out_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      if (redirect_i) begin
        // In-flight instruction is dropped even if decode takes it this cycle.
        pc_q    <= redirect_aligned;
        valid_q <= 1'b0;
        if (redirect_pc_i[1:0] != 2'b00) misalign_q <= 1'b1;
      end else if (capture_en) begin
        instr_q  <= instr_i;
        pc_out_q <= pc_q;
        valid_q  <= 1'b1;
        pc_q     <= pc_q + PC_STEP;
      end else if (fire) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Outputs
  always_comb begin
    pc_addr_o  = pc_q;
    valid_o    = valid_q;
    instr_o    = instr_q;
    pc_o       = pc_out_q;
    pc_plus4_o = pc_out_q + PC_STEP;
    halted_o   = (state_q == HALT);
    misalign_o = misalign_q;
  end

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import ifu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] pc_addr_o;
  logic [31:0] instr_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        halted_o;
  logic        misalign_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [32];

  always #5 clk_i = ~clk_i;

  // Combinational-read instruction memory, word addressed
  always_comb begin
    if (pc_addr_o < 32'd128) instr_i = mem[pc_addr_o[6:2]];
    else                     instr_i = 32'hDEAD_BEEF;
  end

  instr_fetch_unit #(.ADDR_W(32), .MEM_WORDS(32), .RESET_PC(32'h0)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .pc_addr_o     (pc_addr_o),
    .instr_i       (instr_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .halted_o      (halted_o),
    .misalign_o    (misalign_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge; return on the following falling edge for sampling/driving
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] pc);
    check_eq({tag, ".valid"}, 32'(valid_o), 32'(v));
    check_eq({tag, ".pc"}, pc_o, pc);
    check_eq({tag, ".pc4"}, pc_plus4_o, pc + 32'd4);
    check_eq({tag, ".instr"}, instr_o, 32'h1000_0000 + (pc >> 2));
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_i    = 1'b1;
    redirect_pc_i = target;
    step();
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
  endtask

  initial begin
    for (int k = 0; k < 32; k++) mem[k] = 32'h1000_0000 + k;
    rst_i = 1'b0; start_i = 1'b0; redirect_i = 1'b0;
    redirect_pc_i = 32'h0; ready_i = 1'b1;
    #12;
    check_eq("rst.valid", 32'(valid_o), 32'd0);
    check_eq("rst.pc", pc_o, 32'h0);
    check_eq("rst.instr", instr_o, 32'h0);
    check_eq("rst.pc4", pc_plus4_o, 32'd4);
    check_eq("rst.halted", 32'(halted_o), 32'd0);
    check_eq("rst.misalign", 32'(misalign_o), 32'd0);
    check_eq("rst.pcaddr", pc_addr_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    step();
    check_eq("idle.valid", 32'(valid_o), 32'd0);

    // Start and stream
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check_eq("run0.valid", 32'(valid_o), 32'd0);
    step(); check_out("s0", 1'b1, 32'h0);
    step(); check_out("s1", 1'b1, 32'h4);
    step(); check_out("s2", 1'b1, 32'h8);

    // Stall 3 cycles at pc_o=8
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("stall", 1'b1, 32'h8);
      check_eq("stall.pcaddr", pc_addr_o, 32'hC);
    end
    ready_i = 1'b1;
    step(); check_out("rel0", 1'b1, 32'hC);
    step(); check_out("rel1", 1'b1, 32'h10);

    // Redirect with output valid: one bubble
    redirect_to(32'h40);
    check_eq("rd.valid", 32'(valid_o), 32'd0);
    check_eq("rd.pcaddr", pc_addr_o, 32'h40);
    step(); check_out("rd.tgt", 1'b1, 32'h40);
    check_eq("rd.misalign", 32'(misalign_o), 32'd0);

    // Misaligned redirect
    redirect_to(32'h42);
    check_eq("mis.valid", 32'(valid_o), 32'd0);
    check_eq("mis.flag", 32'(misalign_o), 32'd1);
    step(); check_out("mis.tgt", 1'b1, 32'h40);

    // Run off the end
    redirect_to(32'h70);
    step(); check_out("end0", 1'b1, 32'h70);
    step(); check_out("end1", 1'b1, 32'h74);
    step(); check_out("end2", 1'b1, 32'h78);
    step(); check_out("end3", 1'b1, 32'h7C);
    check_eq("end3.halted", 32'(halted_o), 32'd0);
    step();
    check_eq("halt.halted", 32'(halted_o), 32'd1);
    check_eq("halt.valid", 32'(valid_o), 32'd0);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check_eq("halt.start_ign", 32'(halted_o), 32'd1);
    check_eq("halt.valid2", 32'(valid_o), 32'd0);
    check_eq("halt.misalign", 32'(misalign_o), 32'd1);

    // Redirect out of range stays halted; in range resumes
    redirect_to(32'h80);
    check_eq("h80.halted", 32'(halted_o), 32'd1);
    check_eq("h80.pcaddr", pc_addr_o, 32'h80);
    step();
    check_eq("h80.valid", 32'(valid_o), 32'd0);
    redirect_to(32'h0);
    check_eq("h0.halted", 32'(halted_o), 32'd0);
    check_eq("h0.valid", 32'(valid_o), 32'd0);
    step(); check_out("h0.tgt", 1'b1, 32'h0);

    // Async reset in the middle of a stall
    ready_i = 1'b0;
    step(); step();
    check_out("pre_rst", 1'b1, 32'h0);
    #2;
    rst_i = 1'b0;
    #1;
    check_eq("arst.valid", 32'(valid_o), 32'd0);
    check_eq("arst.pc", pc_o, 32'h0);
    check_eq("arst.instr", instr_o, 32'h0);
    check_eq("arst.pc4", pc_plus4_o, 32'd4);
    check_eq("arst.misalign", 32'(misalign_o), 32'd0);
    check_eq("arst.halted", 32'(halted_o), 32'd0);
    check_eq("arst.pcaddr", pc_addr_o, 32'h0);
    check_eq("arst.state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk_i);
    rst_i = 1'b1;
    ready_i = 1'b1;

    // Redirect in IDLE loads the PC and stays idle; start fetches from there
    redirect_i = 1'b1; redirect_pc_i = 32'h20; start_i = 1'b1;
    step();
    redirect_i = 1'b0; redirect_pc_i = 32'h0; start_i = 1'b0;
    check_eq("idle_rd.pcaddr", pc_addr_o, 32'h20);
    check_eq("idle_rd.state", 32'(dut.state_q), 32'(IDLE));
    step();
    check_eq("idle_rd.valid", 32'(valid_o), 32'd0);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step(); check_out("idle_rd.tgt", 1'b1, 32'h20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_instr_fetch_unit
